usb_crc16_checker: RTL and testbench
====================================

USB_CRC16_CHECKER -- requirements
Module: usb_crc16_checker

Interface
REQ-001 SHALL have parameter POLY, default 16'h8005, CRC generator polynomial with the implicit x^16 term omitted.
REQ-002 SHALL have parameter INIT, default 16'hFFFF, register preset at start of packet.
REQ-003 SHALL have parameter RESIDUAL, default 16'h800D, good-packet remainder.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_reset  input  1  synchronous soft clear, active-high.
REQ-007 SHALL have port sop  input  1  start-of-packet strobe.
REQ-008 SHALL have port bit_valid  input  1  serial_in carries a payload bit this cycle.
REQ-009 SHALL have port serial_in  input  1  destuffed data bit, LSB-first, from the serial shift stage.
REQ-010 SHALL have port eop  input  1  end-of-packet strobe.
REQ-011 SHALL have port crc_out  output  16  current CRC register.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port crc_ok  output  1  one-cycle pass pulse.
REQ-014 SHALL have port crc_err  output  1  one-cycle fail pulse.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 SHALL, in IDLE, ignore bit_valid and eop; on sop, load INIT into crc_out and move to ACCUM.
REQ-017 SHALL, on sop with bit_valid in the same cycle, apply that bit to INIT so it counts as the first bit.
REQ-018 SHALL, per valid bit in ACCUM: fb = crc[15] XOR serial_in; crc <= {crc[14:0],0} XOR (fb ? POLY : 0); result is visible on crc_out the next cycle.
REQ-019 SHALL, on eop in ACCUM, go to DONE; a bit_valid in the same cycle is accumulated first.
REQ-020 SHALL, in DONE, assert crc_ok if crc_out == RESIDUAL, else crc_err, for exactly one cycle, then return to IDLE.
REQ-021 SHALL never assert crc_ok and crc_err together, and never assert either outside DONE.
REQ-022 SHALL, on sop in ACCUM, discard the packet, reload INIT, stay in ACCUM, and emit no pulse.
REQ-023 SHALL, on sop in DONE, still emit the verdict, reload INIT and go to ACCUM.
REQ-024 SHALL, on s_reset, override all inputs except n_rst: go to IDLE, set crc_out = INIT, emit no pulse.
REQ-025 SHALL hold crc_out while bit_valid = 0.

Reset
REQ-026 SHALL, on n_rst = 0 at a clock edge: state IDLE, crc_out 16'hFFFF (INIT), busy 0, crc_ok 0, crc_err 0, bit_count 0.
REQ-027 SHALL discard any in-flight packet on reset mid-packet, with no verdict pulse.

Configuration
REQ-028 SHALL, with CRC_BITCNT_EN defined, add output bit_count (11 bits): cleared on sop, incremented per accumulated bit, saturating at 2047, held through DONE.
REQ-029 SHALL, with CRC_BITCNT_EN defined, force crc_err in DONE when fewer than 16 bits were accumulated, regardless of remainder.
REQ-030 SHALL, without CRC_BITCNT_EN, omit the bit_count port and perform no length check.

Structure
REQ-031 SHALL place the state enum and default POLY/INIT/RESIDUAL constants in shared package crc_pkg.
REQ-032 SHALL place the saturating counter in sub-module crc16_bitcnt, instantiated only under CRC_BITCNT_EN.

Verification
REQ-033 SHALL check: sop, one bit 0, eop -> crc_out 16'h7FFB after the bit; crc_err pulse one cycle after eop.
REQ-034 SHALL check: sop, one bit 1 -> crc_out 16'hFFFE.
REQ-035 SHALL check: sop, byte 8'h00 LSB-first, then complement of crc_out MSB-first (16 bits), eop -> crc_out 16'h800D; crc_ok for one cycle; busy low afterwards.
REQ-036 SHALL check: sop then eop with no bits -> crc_err (crc_out 16'hFFFF); with CRC_BITCNT_EN, bit_count 0.
REQ-037 SHALL check: sop, 5 bits, sop again -> no pulse, crc_out 16'hFFFF, bit_count 0.
REQ-038 SHALL check: s_reset, and separately n_rst low, in ACCUM -> IDLE, crc_out 16'hFFFF, no pulse.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the USB CRC16 checker: FSM state encoding, default
// polynomial / preset / residual constants and the single-bit CRC update.
`timescale 1ns/1ps

package crc_pkg;

  // Generator polynomial with the implicit x^16 term omitted.
  localparam logic [15:0] CRC_POLY_DEF     = 16'h8005;
  // Register preset loaded at start of packet.
  localparam logic [15:0] CRC_INIT_DEF     = 16'hFFFF;
  // Remainder left behind by a packet whose appended CRC is intact.
  localparam logic [15:0] CRC_RESIDUAL_DEF = 16'h800D;

  // Width of the optional accumulated-bit counter (saturates at 2047).
  localparam int unsigned BITCNT_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_e;

  // One serial step: feedback is the outgoing MSB XOR the incoming data bit.
  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic        din,
    input logic [15:0] poly
  );
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_bitcnt.sv
// Saturating count of bits accumulated into the CRC for the current packet.
// Only instantiated when CRC_BITCNT_EN is defined.
`timescale 1ns/1ps

module crc16_bitcnt
  import crc_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,  // start of packet or soft clear
  input  logic                inc,    // one bit accumulated this cycle
  output logic [BITCNT_W-1:0] count
);

  localparam logic [BITCNT_W-1:0] CNT_MAX = '1;

  logic [BITCNT_W-1:0] count_q;
  logic [BITCNT_W-1:0] count_d;

  // Next count: a clear restarts at 0 (or 1 when the packet's first bit
  // arrives with the clear), otherwise count up and stick at the maximum.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    count_d = count_q;
    if (clear) begin
      count_d = {{(BITCNT_W-1){1'b0}}, inc};
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/usb_crc16_checker.sv
// Serial USB CRC16 checker. Accumulates destuffed LSB-first bits between
// sop and eop, then emits a one-cycle crc_ok / crc_err verdict by comparing
// the register against the good-packet residual.
// Optional feature macro: CRC_BITCNT_EN adds a saturating bit_count output
// and forces crc_err on packets shorter than 16 accumulated bits.
`timescale 1ns/1ps

module usb_crc16_checker
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY     = CRC_POLY_DEF,
  parameter logic [15:0] INIT     = CRC_INIT_DEF,
  parameter logic [15:0] RESIDUAL = CRC_RESIDUAL_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                s_reset,
  input  logic                sop,
  input  logic                bit_valid,
  input  logic                serial_in,
  input  logic                eop,
  output logic [15:0]         crc_out,
  output logic                busy,
  output logic                crc_ok,
`ifdef CRC_BITCNT_EN
  output logic [BITCNT_W-1:0] bit_count,
`endif
  output logic                crc_err
);

  crc_state_e  state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic        len_ok;
  logic        verdict_cycle;

  // Next-state and CRC update. Soft clear wins over everything; sop restarts
  // a packet from any state (a bit arriving with it is the first bit).
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    if (s_reset) begin
      state_d = ST_IDLE;
      crc_d   = INIT;
    end else if (sop) begin
      state_d = ST_ACCUM;
      crc_d   = bit_valid ? crc16_step(INIT, serial_in, POLY) : INIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACCUM: begin
          if (bit_valid) begin
            crc_d = crc16_step(crc_q, serial_in, POLY);
          end
          if (eop) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and CRC registers; reset drops any in-flight packet silently.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; n_rst is not in the
    // sensitivity list.
    if (!n_rst) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
    end
  end

`ifdef CRC_BITCNT_EN
  logic cnt_clear;
  logic cnt_inc;

  // A bit is accumulated exactly when the CRC register steps.
  assign cnt_clear = s_reset | sop;
  assign cnt_inc   = !s_reset && bit_valid && (sop || (state_q == ST_ACCUM));

  crc16_bitcnt u_bitcnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (bit_count)
  );

  // A packet too short to hold its own CRC can never be good.
  assign len_ok = (bit_count >= BITCNT_W'(16));
`else
  assign len_ok = 1'b1;
`endif

  // The verdict is presented during the single DONE cycle; a coincident
  // soft clear suppresses it.
  assign verdict_cycle = (state_q == ST_DONE) && !s_reset;
  assign crc_ok        = verdict_cycle && (crc_q == RESIDUAL) && len_ok;
  assign crc_err       = verdict_cycle && !((crc_q == RESIDUAL) && len_ok);

  assign crc_out = crc_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_crc16_checker.sv
// Directed bench for usb_crc16_checker. Stimulus pushes the expected verdict
// (pass/fail and the cycle it must appear in) onto a queue; an independent
// monitor pops and compares whenever crc_ok or crc_err is seen.
`timescale 1ns/1ps

module tb_usb_crc16_checker;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        s_reset;
  logic        sop;
  logic        bit_valid;
  logic        serial_in;
  logic        eop;
  logic [15:0] crc_out;
  logic        busy;
  logic        crc_ok;
  logic        crc_err;
`ifdef CRC_BITCNT_EN
  logic [10:0] bit_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit ok;
    int at;
  } verdict_t;

  verdict_t exp_q[$];

  usb_crc16_checker dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .s_reset   (s_reset),
    .sop       (sop),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .eop       (eop),
    .crc_out   (crc_out),
    .busy      (busy),
    .crc_ok    (crc_ok),
`ifdef CRC_BITCNT_EN
    .bit_count (bit_count),
`endif
    .crc_err   (crc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference serial step written straight from the polynomial definition.
  function automatic logic [15:0] model_step(input logic [15:0] c, input logic d);
    logic [15:0] n;
    n = c << 1;
    if (c[15] ^ d) n = n ^ 16'h8005;
    return n;
  endfunction

  // Monitor: any pulse must match the oldest expected verdict.
  always @(negedge clk) begin
    if (crc_ok === 1'b1 || crc_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, crc_ok, crc_err}, 32'd0);
      end else begin
        verdict_t v;
        v = exp_q.pop_front();
        check("verdict_ok", {31'd0, crc_ok}, {31'd0, v.ok});
        check("verdict_err", {31'd0, crc_err}, {31'd0, !v.ok});
        check("verdict_cycle", cyc, v.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected verdict appears in the DONE cycle right after the next edge.
  task automatic expect_verdict(input bit ok);
    verdict_t v;
    v.ok = ok;
    v.at = cyc + 1;
    exp_q.push_back(v);
  endtask

  task automatic send_bit(input logic b, input logic with_eop);
    bit_valid = 1'b1;
    serial_in = b;
    eop       = with_eop;
    tick();
    bit_valid = 1'b0;
    serial_in = 1'b0;
    eop       = 1'b0;
  endtask

  task automatic start_packet();
    sop = 1'b1;
    tick();
    sop = 1'b0;
  endtask

  task automatic check_count(input string name, input int exp);
`ifdef CRC_BITCNT_EN
    check(name, {21'd0, bit_count}, exp);
`else
    if (exp < 0) $display("note: negative count request ignored for %s", name);
`endif
  endtask

  logic [15:0] m;
  logic [4:0]  pat5;

  initial begin
    n_rst = 1'b0; s_reset = 1'b0; sop = 1'b0;
    bit_valid = 1'b0; serial_in = 1'b0; eop = 1'b0;
    tick(); tick();
    check("rst_crc", crc_out, 16'hFFFF);
    check("rst_busy", busy, 0);
    check("rst_ok", crc_ok, 0);
    check("rst_err", crc_err, 0);
    check_count("rst_count", 0);
    n_rst = 1'b1;
    tick();

    // IDLE ignores bit_valid and eop.
    bit_valid = 1'b1; serial_in = 1'b1; eop = 1'b1;
    tick();
    bit_valid = 1'b0; serial_in = 1'b0; eop = 1'b0;
    check("idle_ignore_crc", crc_out, 16'hFFFF);
    check("idle_ignore_busy", busy, 0);

    // Single 0 bit: crc 7FFB, then crc_err one cycle after eop.
    start_packet();
    check("sop_busy", busy, 1);
    check("sop_crc", crc_out, 16'hFFFF);
    send_bit(1'b0, 1'b0);
    check("bit0_crc", crc_out, 16'h7FFB);
    tick();
    check("hold_crc", crc_out, 16'h7FFB);
    eop = 1'b1;
    expect_verdict(1'b0);
    tick();
    eop = 1'b0;
    check("done_busy", busy, 1);
    check_count("bit0_count", 1);
    tick();
    check("after_done_busy", busy, 0);

    // Single 1 bit arriving together with sop.
    sop = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
    tick();
    sop = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
    check("bit1_crc", crc_out, 16'hFFFE);
    check_count("bit1_count", 1);
    eop = 1'b1;
    expect_verdict(1'b0);
    tick();
    eop = 1'b0;
    tick();

    // Byte 0x00 then complemented CRC MSB-first; last bit coincides with eop.
    start_packet();
    m = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 1'b0);
      m = model_step(m, 1'b0);
    end
    check("byte_crc", crc_out, m);
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) expect_verdict(1'b1);
      send_bit(~m[i], (i == 0));
    end
    check("good_residual", crc_out, 16'h800D);
    check("good_busy_done", busy, 1);
    check_count("good_count", 24);
    tick();
    check("good_busy_after", busy, 0);
    check("good_crc_held", crc_out, 16'h800D);

    // Empty packet: sop then eop.
    start_packet();
    eop = 1'b1;
    expect_verdict(1'b0);
    tick();
    eop = 1'b0;
    check("empty_crc", crc_out, 16'hFFFF);
    check_count("empty_count", 0);
    tick();

    // Five bits then a second sop: discard, no pulse.
    start_packet();
    pat5 = 5'b01101;
    for (int i = 0; i < 5; i++) send_bit(pat5[i], 1'b0);
    sop = 1'b1;
    tick();
    sop = 1'b0;
    check("resop_crc", crc_out, 16'hFFFF);
    check("resop_busy", busy, 1);
    check_count("resop_count", 0);

    // Soft clear mid-packet.
    for (int i = 0; i < 3; i++) send_bit(pat5[i], 1'b0);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    check("sreset_busy", busy, 0);
    check("sreset_crc", crc_out, 16'hFFFF);
    check_count("sreset_count", 0);

    // Soft clear coinciding with eop: no verdict.
    start_packet();
    send_bit(1'b1, 1'b0);
    s_reset = 1'b1; eop = 1'b1;
    tick();
    s_reset = 1'b0; eop = 1'b0;
    check("sreset_eop_busy", busy, 0);
    tick();

    // Hard reset mid-packet.
    start_packet();
    for (int i = 0; i < 3; i++) send_bit(pat5[i], 1'b0);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("nrst_busy", busy, 0);
    check("nrst_crc", crc_out, 16'hFFFF);
    check_count("nrst_count", 0);
    tick();

    // sop during DONE: verdict still emitted, new packet starts with its bit.
    start_packet();
    send_bit(1'b0, 1'b0);
    eop = 1'b1;
    expect_verdict(1'b0);
    tick();
    eop = 1'b0;
    sop = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
    tick();
    sop = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
    check("done_sop_busy", busy, 1);
    check("done_sop_crc", crc_out, 16'hFFFE);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;

    tick(); tick(); tick();
    check("pending_verdicts", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
